// File: rtl/mips_harvard_mem.sv
// rtl/mips_harvard_mem.sv - Harvard instruction ROM / data RAM responder with word-serial program loader
//
// Serves the instruction-fetch port and the data port of mips_cpu_harvard.
// After reset the block sits in LOAD and accepts one instruction word per
// cycle on init_mem/init_instr. It moves to RUN on the first idle cycle
// once at least one word is loaded, and only then raises clk_enable.
//
// Optional feature: define MEM_FAULT_EN to build the sticky access-fault flag.
// Without it, fault is tied low and no fault logic exists.
//
// Ports:
//   clk, reset          - clock; asynchronous active-low reset
//   init_mem            - loader strobe, one word per cycle while high
//   init_instr          - instruction word to load
//   init_mem_addr       - byte address the next loaded word will occupy
//   instr_count         - number of words loaded (saturates at INSTR_DEPTH)
//   clk_enable          - CPU clock enable, high only in RUN
//   instr_address       - fetch byte address
//   instr_readdata      - fetched word, NOP when not loaded or misaligned
//   data_address        - data byte address
//   data_write          - write strobe (effective in RUN only)
//   data_read           - read strobe
//   data_writedata      - write data
//   data_readdata       - read data, 0 when not reading or address invalid
//   fault               - sticky access-fault flag
module mips_harvard_mem #(
    parameter logic [31:0] INSTR_BASE  = 32'hBFC00000,
    parameter int          INSTR_DEPTH = 256,
    parameter logic [31:0] DATA_BASE   = 32'h00000000,
    parameter int          DATA_DEPTH  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_mem,
    input  logic [31:0] init_instr,
    output logic [31:0] init_mem_addr,
    output logic [31:0] instr_count,
    output logic        clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        fault
);

    localparam int          IW          = $clog2(INSTR_DEPTH);
    localparam int          DW          = $clog2(DATA_DEPTH);
    localparam logic [31:0] INSTR_WORDS = 32'(INSTR_DEPTH);
    localparam logic [31:0] INSTR_BYTES = 32'(INSTR_DEPTH) << 2;
    localparam logic [31:0] DATA_BYTES  = 32'(DATA_DEPTH) << 2;

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    state_t      state;
    logic [31:0] rom [INSTR_DEPTH];
    logic [31:0] ram [DATA_DEPTH];

    // Offsets relative to each window; an address below the base wraps to
    // a huge offset and therefore falls outside the window naturally.
    logic [31:0] i_off;
    logic [31:0] d_off;
    logic [31:0] d_off_instr;
    logic        i_loaded;
    logic        i_hit;
    logic        d_ok;
    logic        d_in_instr;
    logic        w_en;
    logic        load_room;

    assign i_off       = instr_address - INSTR_BASE;
    assign d_off       = data_address - DATA_BASE;
    assign d_off_instr = data_address - INSTR_BASE;

    assign i_loaded   = {2'b00, i_off[31:2]} < instr_count;
    assign i_hit      = (i_off[1:0] == 2'b00) && i_loaded;
    assign d_ok       = (d_off[1:0] == 2'b00) && (d_off < DATA_BYTES);
    // Guards against a parameterisation where the two windows overlap.
    assign d_in_instr = d_off_instr < INSTR_BYTES;
    assign w_en       = (state == RUN) && data_write && d_ok && !d_in_instr;
    assign load_room  = instr_count < INSTR_WORDS;

    assign instr_readdata = i_hit ? rom[i_off[IW+1:2]] : 32'h00000000;
    // Combinational read sees the pre-edge contents, so a same-cycle
    // read/write to one word returns the old value.
    assign data_readdata  = (data_read && d_ok) ? ram[d_off[DW+1:2]] : 32'h00000000;

    // Memory arrays carry no reset: RAM must survive reset, and the ROM is
    // emptied logically by clearing instr_count.
    always_ff @(posedge clk) begin
        if (state == LOAD && init_mem && load_room) begin
            rom[instr_count[IW-1:0]] <= init_instr;
        end
        if (w_en) begin
            ram[d_off[DW+1:2]] <= data_writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= LOAD;
            clk_enable    <= 1'b0;
            instr_count   <= 32'd0;
            init_mem_addr <= INSTR_BASE;
        end else begin
            case (state)
                LOAD: begin
                    if (init_mem) begin
                        // Overflow words are dropped; count and address
                        // stay pinned at the end of the ROM.
                        if (load_room) begin
                            instr_count   <= instr_count + 32'd1;
                            init_mem_addr <= init_mem_addr + 32'd4;
                        end
                    end else if (instr_count != 32'd0) begin
                        state      <= RUN;
                        clk_enable <= 1'b1;
                    end
                end
                RUN: begin
                    state      <= RUN;
                    clk_enable <= 1'b1;
                end
                default: begin
                    state      <= LOAD;
                    clk_enable <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_FAULT_EN
    logic fault_q;
    logic run_fault;
    logic load_fault;

    assign run_fault  = (state == RUN) &&
                        (((data_read || data_write) && !(d_ok && !d_in_instr)) || !i_loaded);
    assign load_fault = (state == LOAD) && init_mem && !load_room;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (run_fault || load_fault) begin
            fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule
